// File: rtl/synth_pkg.sv
// Shared types and helpers for the time-multiplexed polyphonic synth engine.
// Noise constants are only consumed when SYNTH_NOISE_EN is defined.
package synth_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE       = 2'd0,
        WAVE_SAW          = 2'd1,
        WAVE_TRI          = 2'd2,
        WAVE_SILENT_NOISE = 2'd3
    } wave_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/synth_wave_gen.sv
// Combinational waveform generator: phase + mode -> signed sample.
// With SYNTH_NOISE_EN defined, mode 3 outputs the shared LFSR value instead of silence.
module synth_wave_gen
    import synth_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int PHASE_W  = 32
) (
    input  logic [PHASE_W-1:0]         phase_i,
    input  wave_mode_t                 mode_i,
`ifdef SYNTH_NOISE_EN
    input  logic [15:0]                noise_i,
`endif
    output logic signed [SAMPLE_W-1:0] wave_o
);

    localparam logic [SAMPLE_W-1:0] PEAK = {1'b0, {(SAMPLE_W-1){1'b1}}};

    logic               msb;
    logic [SAMPLE_W-1:0] u;
    logic [SAMPLE_W-1:0] tri_u;
    logic               unused_phase_lsbs;

    assign msb   = phase_i[PHASE_W-1];
    assign u     = phase_i[PHASE_W-2 -: SAMPLE_W];
    assign tri_u = msb ? ~u : u;
    assign unused_phase_lsbs = ^phase_i[PHASE_W-SAMPLE_W-2:0];

    // Subtracting M from an unsigned SAMPLE_W value is just flipping its top bit.
    always_comb begin
        wave_o = '0;
        case (mode_i)
            WAVE_SQUARE: wave_o = msb ? -$signed(PEAK) : $signed(PEAK);
            WAVE_SAW:    wave_o = {~msb, phase_i[PHASE_W-2 -: SAMPLE_W-1]};
            WAVE_TRI:    wave_o = {~tri_u[SAMPLE_W-1], tri_u[SAMPLE_W-2:0]};
`ifdef SYNTH_NOISE_EN
            WAVE_SILENT_NOISE: wave_o = SAMPLE_W'($signed(noise_i));
`endif
            default:     wave_o = '0;
        endcase
    end

endmodule

// File: rtl/poly_synth_engine.sv
// N-voice time-multiplexed synth: one voice per cycle through a 2-stage wave/gain pipe,
// mixed and saturated once per sample_tick. Optional noise voice mode: SYNTH_NOISE_EN.
module poly_synth_engine
    import synth_pkg::*;
#(
    parameter int N_VOICES = 8,
    parameter int SAMPLE_W = 16,
    parameter int PHASE_W  = 32,
    parameter int VOL_W    = 8
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               sample_tick,
    input  logic [N_VOICES-1:0][PHASE_W-1:0]   phase_inc,
    input  logic [N_VOICES-1:0][1:0]           wave_mode,
    input  logic [N_VOICES-1:0]                gate,
    input  logic [N_VOICES-1:0][VOL_W-1:0]     volume,
    input  logic [1:0]                         master_shift,
    input  logic                               clear_overrun,
    output logic signed [SAMPLE_W-1:0]         out_sample,
    output logic                               out_valid,
    output logic                               busy,
    output logic                               overrun
);

    localparam int IDX_W  = $clog2(N_VOICES);
    localparam int ACC_W  = SAMPLE_W + IDX_W + 1;
    localparam int PROD_W = SAMPLE_W + VOL_W + 1;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [N_VOICES-1:0][PHASE_W-1:0] phase_q;
    logic [N_VOICES-1:0]             prev_gate_q;
    logic signed [SAMPLE_W-1:0]      wave_q;
    logic [VOL_W-1:0]                vol_q;
    logic                            s2_vld_q;
    logic signed [ACC_W-1:0]         acc_q;
    logic signed [SAMPLE_W-1:0]      out_sample_q, out_sample_d;
    logic                            out_valid_q;
    logic                            overrun_q, overrun_d;

    // ---- stage 1: select the current voice and generate its wave sample
    logic                       run, g, rise;
    logic [PHASE_W-1:0]         wave_phase;
    wave_mode_t                 mode;
    logic signed [SAMPLE_W-1:0] raw_wave;

    assign run        = (state_q == ST_RUN);
    assign g          = gate[idx_q];
    assign rise       = g & ~prev_gate_q[idx_q];
    assign wave_phase = rise ? '0 : phase_q[idx_q];
    assign mode       = wave_mode_t'(wave_mode[idx_q]);

`ifdef SYNTH_NOISE_EN
    logic [15:0] lfsr_q;
    logic        noise_step;
    assign noise_step = run & g & (mode == WAVE_SILENT_NOISE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        lfsr_q <= LFSR_SEED;
        else if (noise_step) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
    end
`endif

    synth_wave_gen #(.SAMPLE_W(SAMPLE_W), .PHASE_W(PHASE_W)) u_wave (
        .phase_i (wave_phase),
        .mode_i  (mode),
`ifdef SYNTH_NOISE_EN
        .noise_i (lfsr_q),
`endif
        .wave_o  (raw_wave)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= '0;
            prev_gate_q <= '0;
            wave_q      <= '0;
            vol_q       <= '0;
            s2_vld_q    <= 1'b0;
        end else begin
            s2_vld_q <= run;
            if (run) begin
                prev_gate_q[idx_q] <= g;
                wave_q             <= g ? raw_wave : '0;
                vol_q              <= volume[idx_q];
                if (g) phase_q[idx_q] <= wave_phase + phase_inc[idx_q];
            end
        end
    end

    // ---- stage 2: unsigned gain, floor shift, accumulate
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_nxt, mix;

    assign prod    = PROD_W'(wave_q) * PROD_W'($signed({1'b0, vol_q}));
    assign acc_nxt = acc_q + (s2_vld_q ? ACC_W'(prod >>> VOL_W) : '0);
    assign mix     = acc_nxt >>> master_shift;
    assign out_sample_d = SAMPLE_W'(saturate(64'(mix), SAMPLE_W));

    // ---- frame sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: if (sample_tick) begin
                state_d = ST_RUN;
                idx_d   = '0;
            end
            ST_RUN: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(N_VOICES - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A tick landing while busy is dropped; a new event beats a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (sample_tick && busy) overrun_d = 1'b1;
        else if (clear_overrun)  overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            overrun_q   <= overrun_d;
            out_valid_q <= (state_q == ST_DRAIN);
            if (state_q == ST_IDLE && sample_tick) acc_q <= '0;
            else                                   acc_q <= acc_nxt;
            if (state_q == ST_DRAIN) out_sample_q <= out_sample_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_poly_synth_engine.sv
// Directed self-checking bench for poly_synth_engine (default parameters).
module tb_poly_synth_engine;

    localparam int N  = 8;
    localparam int SW = 16;
    localparam int PW = 32;
    localparam int VW = 8;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      sample_tick = 1'b0;
    logic [N-1:0][PW-1:0]      phase_inc;
    logic [N-1:0][1:0]         wave_mode;
    logic [N-1:0]              gate;
    logic [N-1:0][VW-1:0]      volume;
    logic [1:0]                master_shift = 2'd0;
    logic                      clear_overrun = 1'b0;
    logic signed [SW-1:0]      out_sample;
    logic                      out_valid;
    logic                      busy;
    logic                      overrun;

    int checks = 0;
    int errors = 0;

    poly_synth_engine #(.N_VOICES(N), .SAMPLE_W(SW), .PHASE_W(PW), .VOL_W(VW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_tick   (sample_tick),
        .phase_inc     (phase_inc),
        .wave_mode     (wave_mode),
        .gate          (gate),
        .volume        (volume),
        .master_shift  (master_shift),
        .clear_overrun (clear_overrun),
        .out_sample    (out_sample),
        .out_valid     (out_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic clear_voices();
        for (int i = 0; i < N; i++) begin
            phase_inc[i] = '0;
            wave_mode[i] = 2'd3;
            gate[i]      = 1'b0;
            volume[i]    = '0;
        end
    endtask

    // cnt counts cycles since the tick-sampling edge; gives up after 40.
    task automatic wait_valid(inout int cnt);
        while (!out_valid && cnt < 40) begin
            step(1);
            cnt++;
        end
    endtask

    task automatic frame(input string tag, output int smp);
        int cnt;
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        cnt = 1;
        wait_valid(cnt);
        chk({tag, "_latency"}, cnt, N + 2);
        smp = int'(out_sample);
        step(1);
    endtask

    // Gain of 255/256 with floor rounding.
    function automatic int sc(input int w);
        return (w * 255) >>> 8;
    endfunction

    initial begin
        int smp, cnt, pulses;
        int sq_exp[4];
        int tri_exp[8];
        sq_exp  = '{32639, 32639, -32640, -32640};
        tri_exp = '{-32768, -16384, 0, 16384, 32767, 16383, -1, -16385};
        clear_voices();

        // reset state
        step(2);
        chk("rst_out_sample", int'(out_sample), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        step(1);

        // mode 3: noise seed or silence
        wave_mode[0] = 2'd3; gate[0] = 1'b1; volume[0] = 8'd255;
        frame("mode3", smp);
`ifdef SYNTH_NOISE_EN
        chk("noise_first", smp, sc(-21279));
`else
        chk("silent_mode3", smp, 0);
`endif
        do_reset();

        // single square voice, ticks 20 cycles apart
        wave_mode[0] = 2'd0; phase_inc[0] = 32'h4000_0000;
        for (int k = 0; k < 8; k++) begin
            frame($sformatf("square%0d", k), smp);
            chk($sformatf("square%0d_val", k), smp, sq_exp[k % 4]);
            step(9);
        end

        // reset in the middle of a frame (overrun also set first)
        sample_tick = 1'b1; step(1); sample_tick = 1'b0;
        step(1);
        sample_tick = 1'b1; step(1); sample_tick = 1'b0;
        chk("pre_rst_overrun", int'(overrun), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_sample", int'(out_sample), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_overrun", int'(overrun), 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (out_valid) pulses++;
        end
        chk("midrst_no_valid", pulses, 0);
        reset_n = 1'b1;
        step(1);
        frame("post_rst", smp);
        chk("post_rst_val", smp, 32639);

        // overrun set / clear priority
        do_reset();
        sample_tick = 1'b1; step(1); sample_tick = 1'b0;
        cnt = 1;
        step(4); cnt += 4;
        sample_tick = 1'b1; step(1); sample_tick = 1'b0; cnt++;
        chk("ovr_set", int'(overrun), 1);
        wait_valid(cnt);
        chk("ovr_frame_latency", cnt, N + 2);
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            step(1);
            if (out_valid) pulses++;
        end
        chk("ovr_tick_ignored", pulses, 0);
        sample_tick = 1'b1; step(1); sample_tick = 1'b0;
        step(2);
        sample_tick = 1'b1; clear_overrun = 1'b1;
        step(1);
        sample_tick = 1'b0; clear_overrun = 1'b0;
        chk("ovr_set_beats_clear", int'(overrun), 1);
        cnt = 4;
        wait_valid(cnt);
        step(3);
        clear_overrun = 1'b1; step(1); clear_overrun = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);

        // saturation with all voices square
        do_reset();
        for (int i = 0; i < N; i++) begin
            wave_mode[i] = 2'd0; gate[i] = 1'b1; volume[i] = 8'd255; phase_inc[i] = '0;
        end
        frame("sat_pos", smp);
        chk("sat_pos_val", smp, 32767);
        master_shift = 2'd3;
        frame("sat_shift3", smp);
        chk("sat_shift3_val", smp, 32639);
        master_shift = 2'd0;
        for (int i = 0; i < N; i++) phase_inc[i] = 32'h8000_0000;
        frame("sat_pos2", smp);
        chk("sat_pos2_val", smp, 32767);
        frame("sat_neg", smp);
        chk("sat_neg_val", smp, -32768);

        // saw sequence
        clear_voices();
        do_reset();
        wave_mode[0] = 2'd1; gate[0] = 1'b1; volume[0] = 8'd255; phase_inc[0] = 32'h2000_0000;
        for (int k = 0; k < 8; k++) begin
            frame($sformatf("saw%0d", k), smp);
            chk($sformatf("saw%0d_val", k), smp, sc(-32768 + 8192 * k));
        end

        // triangle sequence
        do_reset();
        wave_mode[0] = 2'd2;
        for (int k = 0; k < 8; k++) begin
            frame($sformatf("tri%0d", k), smp);
            chk($sformatf("tri%0d_val", k), smp, sc(tri_exp[k]));
        end

        // triangle peak at phase 0x7FFF_FFFF
        do_reset();
        phase_inc[0] = 32'h7FFF_FFFF;
        frame("tri_pk0", smp);
        chk("tri_pk0_val", smp, -32640);
        frame("tri_pk1", smp);
        chk("tri_pk1_val", smp, 32639);

        // gating: off gives 0, re-gating restarts from phase 0
        do_reset();
        wave_mode[0] = 2'd0; phase_inc[0] = 32'h8000_0000;
        frame("gate_on", smp);
        chk("gate_on_val", smp, 32639);
        gate[0] = 1'b0;
        frame("gate_off", smp);
        chk("gate_off_val", smp, 0);
        gate[0] = 1'b1;
        frame("gate_rise", smp);
        chk("gate_rise_val", smp, 32639);
        frame("gate_next", smp);
        chk("gate_next_val", smp, -32640);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
